vinstr_issuer: RTL and testbench

Issue-side counterpart of the vector core's instruction decoder. It accepts decoded OPIVV requests (op, vd, vs1, vs2, vm) from the scalar side and encodes each into a 32-bit RISC-V OP-V word. Requests are buffered in a small FIFO. Each word is presented to the vector core on `vector_instruction` with a one-cycle `start` pulse, and the issuer holds it until the core reports completion on `vec_done`.

---
 rtl/vinstr_pkg.sv | 51 +++++
 rtl/vinstr_fifo.sv | 64 ++++++
 rtl/vinstr_issuer.sv | 104 ++++++++++
 tb/tb_vinstr_issuer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vinstr_pkg.sv
// Shared definitions for the OPIVV vector instruction issuer: opcode constants,
// operation and FSM enums, and the instruction word encoder.
package vinstr_pkg;

    localparam logic [6:0] OPCODE_OPV   = 7'b1010111;
    localparam logic [2:0] FUNCT3_OPIVV = 3'b000;

    typedef enum logic [2:0] {
        VOP_VADD  = 3'd0,
        VOP_VSUB  = 3'd1,
        VOP_VMINU = 3'd2,
        VOP_VMIN  = 3'd3,
        VOP_VMAX  = 3'd4,
        VOP_VAND  = 3'd5,
        VOP_VOR   = 3'd6,
        VOP_VXOR  = 3'd7
    } vop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issue_state_e;

    function automatic logic [5:0] funct6_of(input vop_e op);
        logic [5:0] f6;
        case (op)
            VOP_VADD:  f6 = 6'b000000;
            VOP_VSUB:  f6 = 6'b000010;
            VOP_VMINU: f6 = 6'b000100;
            VOP_VMIN:  f6 = 6'b000101;
            VOP_VMAX:  f6 = 6'b000111;
            VOP_VAND:  f6 = 6'b001001;
            VOP_VOR:   f6 = 6'b001010;
            VOP_VXOR:  f6 = 6'b001011;
            default:   f6 = 6'b000000;
        endcase
        return f6;
    endfunction

    function automatic logic [31:0] encode_opivv(
        input vop_e       op,
        input logic       vm,
        input logic [4:0] vs2,
        input logic [4:0] vs1,
        input logic [4:0] vd
    );
        return {funct6_of(op), vm, vs2, vs1, FUNCT3_OPIVV, vd, OPCODE_OPV};
    endfunction

endpackage

// File: rtl/vinstr_fifo.sv
// Small synchronous FIFO with show-ahead read data, registered occupancy count
// and full/empty flags derived from it.
module vinstr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vinstr_issuer.sv
// Encodes OPIVV requests into OP-V words, queues them, and hands them one at a
// time to the vector core with a start pulse, waiting for vec_done in between.
module vinstr_issuer
    import vinstr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [4:0]       req_vd,
    input  logic [4:0]       req_vs1,
    input  logic [4:0]       req_vs2,
    input  logic             req_vm,
    output logic             start,
    output logic [31:0]      vector_instruction,
    input  logic             vec_done,
    output logic             busy,
    output logic [CNT_W-1:0] issued_count
);

    issue_state_e     state_q, state_d;
    logic             start_q, start_d;
    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] enc_word;
    logic [31:0] fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    assign enc_word  = encode_opivv(vop_e'(req_op), req_vm, req_vs2, req_vs1, req_vd);
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == ST_IDLE) && !fifo_empty;

    vinstr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The word register only moves on a pop, so it is stable from start to vec_done.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        word_d  = word_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    word_d  = fifo_head;
                    start_d = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (vec_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign start              = start_q;
    assign vector_instruction = word_q;
    assign issued_count       = count_q;
    assign busy               = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vinstr_issuer.sv
// Bench for vinstr_issuer: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based transaction model.
module tb_vinstr_issuer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [4:0]       req_vd;
    logic [4:0]       req_vs1;
    logic [4:0]       req_vs2;
    logic             req_vm;
    logic             start;
    logic [31:0]      vector_instruction;
    logic             vec_done;
    logic             busy;
    logic [CNT_W-1:0] issued_count;

    vinstr_issuer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_vd             (req_vd),
        .req_vs1            (req_vs1),
        .req_vs2            (req_vs2),
        .req_vm             (req_vm),
        .start              (start),
        .vector_instruction (vector_instruction),
        .vec_done           (vec_done),
        .busy               (busy),
        .issued_count       (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queued words, the word in flight and how long it has been out.
    logic [31:0] mq[$];
    bit          m_inflight;
    int          m_age;
    logic        m_start;
    logic [31:0] m_word;
    int          m_cnt;
    int          n_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int op, input int vd, input int vs1,
                                             input int vs2, input int vm);
        int f6 [8] = '{0, 2, 4, 5, 7, 9, 10, 11};
        return 32'(f6[op] * (1 << 26) + vm * (1 << 25) + vs2 * (1 << 20)
                   + vs1 * (1 << 15) + vd * (1 << 7) + 87);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_inflight = 0;
        m_age      = 0;
        m_start    = 1'b0;
        m_word     = '0;
        m_cnt      = 0;
    endtask

    task automatic model_edge();
        bit          acc;
        logic [31:0] w;
        if (!rstn) begin
            model_clear();
            return;
        end
        acc = req_valid && (mq.size() < DEPTH);
        w   = exp_word(int'(req_op), int'(req_vd), int'(req_vs1), int'(req_vs2), int'(req_vm));
        m_start = 1'b0;
        if (!m_inflight) begin
            if (mq.size() > 0) begin
                m_word     = mq.pop_front();
                m_start    = 1'b1;
                m_cnt      = m_cnt + 1;
                m_inflight = 1;
                m_age      = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (vec_done) begin
            m_inflight = 0;
        end
        if (acc) begin
            mq.push_back(w);
            n_acc++;
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model at the edge.
    task automatic step();
        @(negedge clk);
        check("ready", 32'(req_ready), 32'(mq.size() < DEPTH));
        check("busy", 32'(busy), 32'(m_inflight || mq.size() > 0));
        check("start", 32'(start), 32'(m_start));
        check("word", vector_instruction, m_word);
        check("count", 32'(issued_count), 32'(m_cnt[CNT_W-1:0]));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_req();
        req_op  = 3'($urandom_range(0, 7));
        req_vd  = 5'($urandom_range(0, 31));
        req_vs1 = 5'($urandom_range(0, 31));
        req_vs2 = 5'($urandom_range(0, 31));
        req_vm  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [31:0] held;
        int          guard;
        rstn      = 1'b0;
        req_valid = 1'b0;
        vec_done  = 1'b0;
        rand_req();
        model_clear();
        n_acc = 0;
        #3;
        check("rst_start", 32'(start), 32'd0);
        check("rst_word", vector_instruction, 32'd0);
        check("rst_count", 32'(issued_count), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single vadd request
        req_op = 3'd0; req_vd = 5'd20; req_vs2 = 5'd10; req_vs1 = 5'd5; req_vm = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("vadd_start", 32'(start), 32'd1);
        check("vadd_word", vector_instruction, 32'h02A28A57);
        check("vadd_count", 32'(issued_count), 32'd1);
        repeat (3) step();
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        step();

        // Single vsub request, masked
        req_op = 3'd1; req_vd = 5'd1; req_vs2 = 5'd2; req_vs1 = 5'd3; req_vm = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("vsub_word", vector_instruction, 32'h082180D7);
        repeat (2) step();
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        step();

        // Back-pressure: valid every cycle, no completions
        n_acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_req();
            step();
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(n_acc), 32'd5);
        check("bp_ready", 32'(req_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);

        // Completion gating: vec_done during ISSUE must be ignored
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        step();
        check("gate_issue", 32'(start), 32'd1);
        held = vector_instruction;
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        repeat (3) step();
        check("gate_held", vector_instruction, held);
        check("gate_nostart", 32'(start), 32'd0);
        vec_done = 1'b1;
        step();
        vec_done = 1'b0;
        step();
        check("gate_next", 32'(start), 32'd1);

        // Reset while waiting with three entries queued
        req_valid = 1'b1;
        rand_req();
        step();
        req_valid = 1'b0;
        repeat (2) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        model_clear();
        check("mid_rst_start", 32'(start), 32'd0);
        check("mid_rst_word", vector_instruction, 32'd0);
        check("mid_rst_count", 32'(issued_count), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rstn = 1'b1;
        vec_done = 1'b1;
        repeat (6) step();
        check("post_rst_nostart", 32'(issued_count), 32'd0);

        // Counter wrap: 256 issues with vec_done held high
        n_acc = 0;
        guard = 0;
        while (!(n_acc == 256 && mq.size() == 0 && !m_inflight) && guard < 3000) begin
            req_valid = (n_acc < 256);
            rand_req();
            step();
            guard++;
        end
        req_valid = 1'b0;
        check("wrap_timeout", 32'(guard < 3000), 32'd1);
        check("wrap_count", 32'(issued_count), 32'd0);
        vec_done = 1'b0;

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            vec_done  = ($urandom_range(0, 9) < 3);
            rand_req();
            step();
        end
        req_valid = 1'b0;
        vec_done  = 1'b1;
        repeat (20) step();
        check("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
